// File: rtl/vga_raster_timing.sv
// Raster timing generator for the cellular-automaton video renderers.
// Walks an H_TOTAL x V_TOTAL raster, hands the coordinates to the renderer,
// takes its RGB back and drives sync/blank/RGB to the DAC with matching latency.
module vga_raster_timing #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 48,
  parameter int unsigned H_SYNC   = 112,
  parameter int unsigned H_BP     = 248,
  parameter int unsigned V_ACTIVE = 1024,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 38,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  // Renderer latency from coordinates to RGB, 0..4.
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic signed [11:0] oX_video,
  output logic signed [11:0] oY_video,
  output logic               endFrame,
  output logic [31:0]        frame_cnt,
  input  logic [7:0]         iR_video,
  input  logic [7:0]         iG_video,
  input  logic [7:0]         iB_video,
  output logic               oHS,
  output logic               oVS,
  output logic               oBlank,
  output logic [7:0]         oR,
  output logic [7:0]         oG,
  output logic [7:0]         oB
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] HLast    = 12'(H_TOTAL - 1);
  localparam logic [11:0] VLast    = 12'(V_TOTAL - 1);
  localparam logic [11:0] HActive  = 12'(H_ACTIVE);
  localparam logic [11:0] VActive  = 12'(V_ACTIVE);
  localparam logic [11:0] HsStart  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HsEnd    = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VsStart  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VsEnd    = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Packed {hs, vs, blank} as carried through the alignment pipeline.
  localparam logic [2:0]  SyncIdle = {~HS_POL, ~VS_POL, 1'b1};

  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;
  logic        h_wrap, v_wrap, frame_wrap;
  logic        end_flag_q;
  logic [31:0] frame_cnt_q;

  logic        hs_raw, vs_raw, blank_raw;
  logic [2:0]  sync_raw;
  logic [2:0]  sync_dly;

  logic        hs_q, vs_q, blank_q;
  logic [7:0]  r_q, g_q, b_q;

  // Next-state for the raster counters.
  always_comb begin
    h_wrap     = (h_q == HLast);
    v_wrap     = (v_q == VLast);
    frame_wrap = h_wrap & v_wrap;
    h_d        = h_wrap ? 12'd0 : h_q + 12'd1;
    v_d        = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? 12'd0 : v_q + 12'd1;
    end
  end

  // Raster counters, last-pixel flag and frame counter; all hold while pix_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q         <= 12'd0;
      v_q         <= 12'd0;
      end_flag_q  <= 1'b0;
      frame_cnt_q <= 32'd0;
    end else if (pix_en) begin
      h_q        <= h_d;
      v_q        <= v_d;
      end_flag_q <= (h_d == HLast) && (v_d == VLast);
      if (frame_wrap) begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end
    end
  end

  // The flag marks the last pixel; qualifying with pix_en confines the pulse to the
  // one enabled cycle spent there, however long pix_en stays low around it.
  assign endFrame  = end_flag_q & pix_en;
  assign frame_cnt = frame_cnt_q;
  assign oX_video  = $signed(h_q);
  assign oY_video  = $signed(v_q);

  // Undelayed sync/blank decoded from the current coordinates.
  always_comb begin
    hs_raw    = ((h_q >= HsStart) && (h_q <= HsEnd)) ? HS_POL : ~HS_POL;
    vs_raw    = ((v_q >= VsStart) && (v_q <= VsEnd)) ? VS_POL : ~VS_POL;
    blank_raw = (h_q >= HActive) || (v_q >= VActive);
    sync_raw  = {hs_raw, vs_raw, blank_raw};
  end

  // Delay line matching the renderer latency.
  if (PIPE_DLY == 0) begin : g_no_dly
    assign sync_dly = sync_raw;
  end else if (PIPE_DLY == 1) begin : g_dly_one
    logic [2:0] sr_q;

    // Single stage, advancing with the raster.
    always_ff @(posedge clk) begin
      if (rst) begin
        sr_q <= SyncIdle;
      end else if (pix_en) begin
        sr_q <= sync_raw;
      end
    end

    assign sync_dly = sr_q;
  end else begin : g_dly_multi
    logic [PIPE_DLY-1:0][2:0] sr_q;

    // Shift register, stage 0 newest, advancing with the raster.
    always_ff @(posedge clk) begin
      if (rst) begin
        sr_q <= {PIPE_DLY{SyncIdle}};
      end else if (pix_en) begin
        sr_q <= {sr_q[PIPE_DLY-2:0], sync_raw};
      end
    end

    assign sync_dly = sr_q[PIPE_DLY-1];
  end

  // Output register: aligned sync/blank and blank-gated renderer RGB.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b1;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      b_q     <= 8'd0;
    end else if (pix_en) begin
      hs_q    <= sync_dly[2];
      vs_q    <= sync_dly[1];
      blank_q <= sync_dly[0];
      r_q     <= sync_dly[0] ? 8'd0 : iR_video;
      g_q     <= sync_dly[0] ? 8'd0 : iG_video;
      b_q     <= sync_dly[0] ? 8'd0 : iB_video;
    end
  end

  assign oHS    = hs_q;
  assign oVS    = vs_q;
  assign oBlank = blank_q;
  assign oR     = r_q;
  assign oG     = g_q;
  assign oB     = b_q;

endmodule

// File: tb/tb_vga_raster_timing.sv
// Bench for vga_raster_timing on a reduced 16x11 raster (8 active pixels, 6 active lines,
// hsync at h=10..12, vsync at v=7..8, PIPE_DLY=1) so whole frames fit in a short run.
module tb_vga_raster_timing;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               pix_en = 1'b0;
  logic signed [11:0] oX_video, oY_video;
  logic               endFrame;
  logic [31:0]        frame_cnt;
  logic [7:0]         iR_video = 8'hA5;
  logic [7:0]         iG_video = 8'h3C;
  logic [7:0]         iB_video = 8'hFF;
  logic               oHS, oVS, oBlank;
  logic [7:0]         oR, oG, oB;

  int n_chk = 0;
  int n_err = 0;

  vga_raster_timing #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (3),
    .V_ACTIVE (6),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (2),
    .HS_POL   (1'b1),
    .VS_POL   (1'b1),
    .PIPE_DLY (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .oX_video  (oX_video),
    .oY_video  (oY_video),
    .endFrame  (endFrame),
    .frame_cnt (frame_cnt),
    .iR_video  (iR_video),
    .iG_video  (iG_video),
    .iB_video  (iB_video),
    .oHS       (oHS),
    .oVS       (oVS),
    .oBlank    (oBlank),
    .oR        (oR),
    .oG        (oG),
    .oB        (oB)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;      // enabled cycles since reset
    int x;
    int y;
    bit hs;
    bit vs;
    bit blank;
    bit ef;
    int fc;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    pix_en = 1'b1;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    pix_en = 1'b0;
    tick();
    rst    = 1'b0;
    pix_en = 1'b1;
  endtask

  int t_now;
  int ef_cnt, hs_cnt, vs_cnt, act_cnt, rgb_bad, ef_bad;

  initial begin
    //            t    x   y  hs vs bl ef fc
    tbl[0]  = '{  0,   0,  0, 0, 0, 1, 0, 0};
    tbl[1]  = '{  1,   1,  0, 0, 0, 1, 0, 0};
    tbl[2]  = '{  2,   2,  0, 0, 0, 0, 0, 0};
    tbl[3]  = '{  9,   9,  0, 0, 0, 0, 0, 0};
    tbl[4]  = '{ 10,  10,  0, 0, 0, 1, 0, 0};
    tbl[5]  = '{ 12,  12,  0, 1, 0, 1, 0, 0};
    tbl[6]  = '{ 14,  14,  0, 1, 0, 1, 0, 0};
    tbl[7]  = '{ 15,  15,  0, 0, 0, 1, 0, 0};
    tbl[8]  = '{ 16,   0,  1, 0, 0, 1, 0, 0};
    tbl[9]  = '{ 18,   2,  1, 0, 0, 0, 0, 0};
    tbl[10] = '{113,   1,  7, 0, 0, 1, 0, 0};
    tbl[11] = '{114,   2,  7, 0, 1, 1, 0, 0};
    tbl[12] = '{124,  12,  7, 1, 1, 1, 0, 0};
    tbl[13] = '{145,   1,  9, 0, 1, 1, 0, 0};
    tbl[14] = '{146,   2,  9, 0, 0, 1, 0, 0};
    tbl[15] = '{175,  15, 10, 0, 0, 1, 1, 0};
    tbl[16] = '{176,   0,  0, 0, 0, 1, 0, 1};
    tbl[17] = '{178,   2,  0, 0, 0, 0, 0, 1};
    tbl[18] = '{351,  15, 10, 0, 0, 1, 1, 1};
    tbl[19] = '{352,   0,  0, 0, 0, 1, 0, 2};

    // Continuous pix_en: coordinates, sync, blank, RGB gating, endFrame, frame_cnt.
    do_reset();
    t_now = 0;
    for (int i = 0; i < 20; i++) begin
      adv(tbl[i].t - t_now);
      t_now = tbl[i].t;
      check($sformatf("v%0d.x", i), {20'd0, oX_video}, 32'(tbl[i].x));
      check($sformatf("v%0d.y", i), {20'd0, oY_video}, 32'(tbl[i].y));
      check($sformatf("v%0d.hs", i), 32'(oHS), 32'(tbl[i].hs));
      check($sformatf("v%0d.vs", i), 32'(oVS), 32'(tbl[i].vs));
      check($sformatf("v%0d.blank", i), 32'(oBlank), 32'(tbl[i].blank));
      check($sformatf("v%0d.endFrame", i), 32'(endFrame), 32'(tbl[i].ef));
      check($sformatf("v%0d.frame_cnt", i), frame_cnt, 32'(tbl[i].fc));
      check($sformatf("v%0d.r", i), 32'(oR), tbl[i].blank ? 32'h0 : 32'hA5);
      check($sformatf("v%0d.g", i), 32'(oG), tbl[i].blank ? 32'h0 : 32'h3C);
      check($sformatf("v%0d.b", i), 32'(oB), tbl[i].blank ? 32'h0 : 32'hFF);
    end

    // One whole frame from reset: pulse and sync/active counts.
    do_reset();
    ef_cnt = 0; hs_cnt = 0; vs_cnt = 0; act_cnt = 0; rgb_bad = 0;
    for (int i = 0; i < 176; i++) begin
      if (endFrame) ef_cnt++;
      if (oHS) hs_cnt++;
      if (oVS) vs_cnt++;
      if (!oBlank) act_cnt++;
      if (oBlank ? (oR != 8'h00 || oG != 8'h00 || oB != 8'h00)
                 : (oR != 8'hA5 || oG != 8'h3C || oB != 8'hFF)) rgb_bad++;
      tick();
    end
    check("frame.endFrame_pulses", 32'(ef_cnt), 32'd1);
    check("frame.hs_cycles", 32'(hs_cnt), 32'd33);
    check("frame.vs_cycles", 32'(vs_cnt), 32'd32);
    check("frame.active_cycles", 32'(act_cnt), 32'd48);
    check("frame.rgb_gating_errors", 32'(rgb_bad), 32'd0);
    check("frame.x_after", {20'd0, oX_video}, 32'd0);
    check("frame.frame_cnt_after", frame_cnt, 32'd1);

    // pix_en toggling every other cycle: 352 clocks make one frame.
    do_reset();
    ef_cnt = 0; ef_bad = 0;
    for (int i = 0; i < 352; i++) begin
      pix_en = (i % 2 == 0);
      #1;
      if (endFrame) ef_cnt++;
      if (endFrame && !pix_en) ef_bad++;
      tick();
    end
    check("toggle.endFrame_pulses", 32'(ef_cnt), 32'd1);
    check("toggle.endFrame_while_disabled", 32'(ef_bad), 32'd0);
    check("toggle.x", {20'd0, oX_video}, 32'd0);
    check("toggle.y", {20'd0, oY_video}, 32'd0);
    check("toggle.frame_cnt", frame_cnt, 32'd1);
    pix_en = 1'b0;
    repeat (5) tick();
    check("hold.x", {20'd0, oX_video}, 32'd0);
    check("hold.blank", 32'(oBlank), 32'd1);
    check("hold.endFrame", 32'(endFrame), 32'd0);
    adv(1);
    check("hold.x_resume", {20'd0, oX_video}, 32'd1);
    adv(1);
    check("hold.blank_resume", 32'(oBlank), 32'd0);
    check("hold.r_resume", 32'(oR), 32'hA5);

    // Mid-frame reset in the second frame at h=5, v=3.
    do_reset();
    adv(229);
    check("mrst.x_before", {20'd0, oX_video}, 32'd5);
    check("mrst.y_before", {20'd0, oY_video}, 32'd3);
    check("mrst.fc_before", frame_cnt, 32'd1);
    rst = 1'b1;
    pix_en = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst.x", {20'd0, oX_video}, 32'd0);
    check("mrst.y", {20'd0, oY_video}, 32'd0);
    check("mrst.blank", 32'(oBlank), 32'd1);
    check("mrst.rgb", {8'd0, oR, oG, oB}, 32'd0);
    check("mrst.fc", frame_cnt, 32'd0);
    check("mrst.endFrame", 32'(endFrame), 32'd0);
    check("mrst.hs", 32'(oHS), 32'd0);
    adv(2);
    check("mrst.x_resume", {20'd0, oX_video}, 32'd2);
    check("mrst.blank_resume", 32'(oBlank), 32'd0);
    check("mrst.g_resume", 32'(oG), 32'h3C);

    // frame_cnt wrap from all-ones.
    do_reset();
    pix_en = 1'b0;
    force dut.frame_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    check("wrap.preload", frame_cnt, 32'hFFFF_FFFF);
    adv(175);
    check("wrap.endFrame", 32'(endFrame), 32'd1);
    check("wrap.fc_last_pixel", frame_cnt, 32'hFFFF_FFFF);
    adv(1);
    check("wrap.fc", frame_cnt, 32'd0);
    check("wrap.endFrame_after", 32'(endFrame), 32'd0);
    check("wrap.x", {20'd0, oX_video}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
